uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte producers in the 3.125 MHz UART subsystem. It accepts byte requests, picks one winner fairly, hands that byte to the transmitter with a single start pulse, and waits for the transmitter's completion pulse. It then tells the owner the outcome and enforces an idle guard time on the line before the next frame. A watchdog recovers the arbiter if the transmitter never reports completion.

## Interface
- `NUM_REQ`, default 3: number of requesters, range 2–8.
- `GAP_CYCLES`, default 14: idle clocks between frames (one bit time).
- `TIMEOUT_CYCLES`, default 336: maximum clocks to wait for `tx_done` (two 12-bit frame times).
- `clk_3125`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `NUM_REQ`  level request, one bit per requester; requester `i` holds it until it sees `gnt[i]`.
- `req_data`  in  `8*NUM_REQ`  byte for requester `i` at bits `[8i+7:8i]`; must be stable while `req[i]` is high.
- `tx_done`  in  1  one-cycle pulse from the transmitter when the stop bit is finished.
- `gnt`  out  `NUM_REQ`  one-hot, one-cycle pulse: byte latched from requester `i`.
- `tx_start`  out  1  one-cycle pulse telling the transmitter to begin a frame.
- `tx_data`  out  8  byte to transmit; held from `tx_start` until the next grant.
- `done`  out  `NUM_REQ`  one-hot, one-cycle pulse: requester `i`'s byte was sent.
- `err`  out  `NUM_REQ`  one-hot, one-cycle pulse: requester `i`'s byte timed out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, GRANT, WAIT_DONE, GAP.
- **IDLE**
  - If any `req` bit is high, choose the winner by round-robin, latch the winner index and its byte, and go to GRANT.
  - `tx_done` is ignored in this state.
- **Round-robin rule**
  - Search starts at `last + 1` (mod `NUM_REQ`) and ascends; the first set bit wins.
  - `last` is updated to the winner when a grant is issued.
  - Reset value of `last` is `NUM_REQ-1`, so requester 0 has first priority.
- **GRANT** (exactly one cycle)
  - `gnt[win]=1`, `tx_start=1`, `tx_data` = latched byte.
  - Clear the timeout counter, then go to WAIT_DONE.
- **WAIT_DONE**
  - Count cycles.
  - If `tx_done=1`: pulse `done[win]` and go to GAP.
  - Else, if the count reaches `TIMEOUT_CYCLES-1`: pulse `err[win]` and go to GAP.
  - If `tx_done` arrives on the same cycle as the timeout, `tx_done` wins: `done` pulses and `err` does not.
- **GAP**
  - Count `GAP_CYCLES` cycles, then go to IDLE.
  - `req` is not sampled in WAIT_DONE or GAP.
  - A `req` still held afterwards is arbitrated again in IDLE, so a requester that keeps `req` high sends another byte, still in fair rotation.
- **Counters:** one shared counter, width `clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)+1)`. It must not wrap; it is cleared on every state entry.
- **Edge cases**
  - `NUM_REQ=1` is not supported.
  - If `req` drops before the grant (a protocol violation), the latched byte is still sent.
- **Reset:** all outputs go to 0, state to IDLE, `last` to `NUM_REQ-1`, counter to 0, `tx_data` to 0. Reset mid-frame aborts without emitting `done` or `err`.

## Timing
- All outputs are registered; `gnt`, `tx_start`, `done` and `err` are exactly one cycle wide.
- **Grant latency:** with `req` high and state IDLE at rising edge k, `gnt`, `tx_start` and the new `tx_data` are high during the cycle between edges k+1 and k+2.
- **Completion:** `tx_done` sampled at edge m produces `done[win]` high during the cycle between edges m+1 and m+2. The state is GAP for `GAP_CYCLES` cycles, and the earliest next `tx_start` is edge m+`GAP_CYCLES`+2.
- **Timeout:** `err` is asserted `TIMEOUT_CYCLES` cycles after the `tx_start` cycle.
- **`busy`:** rises with `gnt` and falls on the first IDLE cycle.
- **Minimum frame-to-frame spacing** (start to start) = transmitter frame time + `GAP_CYCLES` + 2 cycles.

## Test plan
- **Single requester:** `req=3'b001`, `req_data[7:0]=8'h41`. Expect `gnt=001` and `tx_start` one cycle after IDLE sampling, with `tx_data=8'h41`. Drive `tx_done` 168 cycles later; expect `done=001` one cycle after, `busy` low 14 cycles after that.
- **Round-robin:** hold `req=3'b111` with bytes 0x10/0x20/0x30 and answer every `tx_start` with `tx_done`. Expect `tx_data` order 0x10, 0x20, 0x30, 0x10, and `gnt` order 001, 010, 100, 001.
- **Rotation after reset:** after a grant to requester 1, `req=3'b011` must grant requester 0 next. Then assert `rst` and apply `req=3'b011`: requester 0 wins.
- **Timeout:** grant requester 2 and never assert `tx_done`. Expect `err=100` 336 cycles after `tx_start`, no `done`, and a return to IDLE after 14 GAP cycles.
- **Simultaneous done and timeout:** pulse `tx_done` exactly on the timeout cycle. Expect `done` asserted and `err` held at 0.
- **Reset mid-frame:** assert `rst` asynchronously during WAIT_DONE. All outputs are 0 immediately, with no `done` or `err`. After release, a pending `req=3'b001` is granted one cycle after IDLE sampling, and stray `tx_done` pulses in IDLE are ignored.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Every output is registered and trails the FSM state by one clock. A grant
// decided at edge k is therefore visible between edges k+1 and k+2. A frame
// outcome decided at edge m is visible between edges m+1 and m+2.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int GAP_CYCLES     = 14,
  parameter int TIMEOUT_CYCLES = 336
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic                 tx_done,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t             state_r, next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_inc_s;
  logic [IDX_W-1:0]   last_r, win_r, win_s, cand_s;
  logic [7:0]         byte_r, byte_s;
  logic               found_s, done_ev_s, err_ev_s;
  logic               done_pend_r, err_pend_r;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [NUM_REQ-1:0] gnt_r, done_r, err_r;
  logic               tx_start_r, busy_r;
  logic [7:0]         tx_data_r;

  assign gnt      = gnt_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;
  assign done     = done_r;
  assign err      = err_r;
  assign busy     = busy_r;

  // Round-robin pick: search ascends from last+1 (mod NUM_REQ); first set bit wins.
  always_comb begin
    win_s   = last_r;
    found_s = 1'b0;
    cand_s  = last_r;
    byte_s  = 8'h00;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(last_r) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        win_s   = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == IDX_W'(i)) begin
        byte_s = req_data[8*i +: 8];
      end else begin
        byte_s = byte_s;
      end
    end
  end

  // One-hot decode of the latched winner, shared by gnt, done and err.
  always_comb begin
    win_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_r;
  end

  // Next-state logic and frame-outcome events.
  // The timeout test looks at cnt+1 so that err lands exactly TIMEOUT_CYCLES
  // cycles after the tx_start cycle. tx_done is checked first, so it wins a tie.
  always_comb begin
    next_s    = state_r;
    done_ev_s = 1'b0;
    err_ev_s  = 1'b0;
    cnt_inc_s = cnt_r + CNT_ONE;
    case (state_r)
      IDLE: begin
        if (|req) next_s = GRANT;
        else      next_s = IDLE;
      end
      GRANT: begin
        next_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_ev_s = 1'b1;
          next_s    = GAP;
        end else if (cnt_inc_s == TO_LAST) begin
          err_ev_s  = 1'b1;
          next_s    = GAP;
        end else begin
          next_s    = WAIT_DONE;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) next_s = IDLE;
        else                   next_s = GAP;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Shared cycle counter: cleared on every state change, saturates instead of wrapping.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst)                     cnt_r <= CNT_ZERO;
    else if (next_s != state_r)  cnt_r <= CNT_ZERO;
    else if (cnt_r != CNT_SAT)   cnt_r <= cnt_inc_s;
    else                         cnt_r <= cnt_r;
  end

  // Latch the winner, its byte and the rotation pointer when leaving IDLE.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      last_r <= LAST_RST;
      win_r  <= {IDX_W{1'b0}};
      byte_r <= 8'h00;
    end else if (state_r == IDLE && (|req)) begin
      last_r <= win_s;
      win_r  <= win_s;
      byte_r <= byte_s;
    end else begin
      last_r <= last_r;
      win_r  <= win_r;
      byte_r <= byte_r;
    end
  end

  // Registered outputs; done/err go through a pending flag to line up with the state lag.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      gnt_r       <= {NUM_REQ{1'b0}};
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      done_pend_r <= 1'b0;
      err_pend_r  <= 1'b0;
      done_r      <= {NUM_REQ{1'b0}};
      err_r       <= {NUM_REQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      gnt_r       <= (state_r == GRANT) ? win_oh_s : {NUM_REQ{1'b0}};
      tx_start_r  <= (state_r == GRANT);
      tx_data_r   <= (state_r == GRANT) ? byte_r : tx_data_r;
      done_pend_r <= done_ev_s;
      err_pend_r  <= err_ev_s;
      done_r      <= done_pend_r ? win_oh_s : {NUM_REQ{1'b0}};
      err_r       <= err_pend_r ? win_oh_s : {NUM_REQ{1'b0}};
      busy_r      <= (state_r != IDLE) && (next_s != IDLE);
    end
  end

endmodule
